bram_weight_loader: RTL and testbench
=====================================

Name: bram_weight_loader

Overview:
- Write-side counterpart of the weight BRAM read controller. It fills the weight BRAM from the AXI side.
- Accepts a stream of 32-bit words over a valid/ready handshake and packs them into 5*MAC_NUM-bit weight lines.
- Writes each completed line to one sequential BRAM address through port A.
- Sits between the AXI slave data path and the weight BRAM. It runs before the MAC array reads weights through the read controller.

Parameters:
- MAC_NUM, 256: number of MACs; line width LW = 5*MAC_NUM bits.
- BRAM_ADDRESS_WIDTH, 12: BRAM address width.
- IN_WIDTH, 32: input word width. WPL = ceil(LW/IN_WIDTH) words per line; default WPL = 40.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- load_base  in  BRAM_ADDRESS_WIDTH  first line address, latched on load_start.
- load_abort  in  1  abandons the load; any partial line is discarded.
- s_data  in  IN_WIDTH  input word.
- s_valid  in  1  s_data is valid.
- s_last  in  1  qualifies the final word of the load.
- s_ready  out  1  loader accepts a word this cycle.
- bram_wr_data  out  LW  registered line data.
- bram_wr_address  out  BRAM_ADDRESS_WIDTH  registered line address.
- bram_we  out  1  write strobe, high one cycle per line.
- bram_en  out  1  port enable; equals bram_we.
- busy  out  1  high in FILL, WRITE or DONE.
- load_done  out  1  one-cycle pulse when the load completes.
- lines_written  out  BRAM_ADDRESS_WIDTH+1  number of lines written in the current or last load.
- addr_wrap  out  1  sticky flag: the address wrapped past all-ones.

Behaviour:
- States: IDLE, FILL, WRITE, DONE.
- Reset values:
  - state = IDLE.
  - All outputs = 0; bram_wr_data = 0.
  - Word counter, line buffer and last_seen = 0.
- Handshake: a word transfers when s_valid && s_ready. s_ready = 1 only in FILL. Input is ignored in all other states.
- Packing:
  - Word k of a line occupies line bits [IN_WIDTH*k+IN_WIDTH-1 : IN_WIDTH*k].
  - Bits of the final word above LW are dropped.
  - The line buffer is cleared to 0 when each line starts, so a short line is zero-padded.
- IDLE:
  - On load_start: address <= load_base; lines_written <= 0; addr_wrap <= 0; word counter <= 0; buffer <= 0; go to FILL.
  - load_start outside IDLE is ignored.
- FILL:
  - On each transfer, store the word at the current word index and increment the counter.
  - Go to WRITE when the transfer carries s_last, or when the counter reaches WPL-1. Set last_seen if s_last.
  - s_last on word 0 still produces a one-line write.
- WRITE (one cycle, s_ready = 0):
  - bram_we = bram_en = 1; bram_wr_data = buffer; bram_wr_address = current address.
  - Next edge: address <= address+1, wrapping modulo 2^BRAM_ADDRESS_WIDTH. If the old address was all-ones, set addr_wrap.
  - lines_written increments by 1.
  - If last_seen, go to DONE; otherwise clear the counter and buffer and go to FILL.
- DONE: load_done = 1 for one cycle, then IDLE. lines_written and addr_wrap hold until the next load_start.
- Latency: from the last accepted word of a line to bram_we is 1 cycle. Full-line throughput is WPL+1 cycles per line.
- load_abort (any state except IDLE) has priority over every other transition:
  - Next state IDLE, no write, no load_done.
  - A WRITE cycle coinciding with abort still drives bram_we that cycle; the abort takes effect at the following edge.
  - lines_written keeps the count of committed lines.
- s_last with s_valid low has no effect.
- Asynchronous reset mid-load returns to IDLE immediately and clears all outputs.

Test Plan:
- Full load:
  - Stimulus: load_base = 0x010, 80 words, value = index, s_last on word 79, s_valid always 1.
  - Response: bram_we pulses at addresses 0x010 and 0x011, each 41 cycles apart. Line 0 bits [31:0] = 0 and bits [1279:1248] = 39. load_done follows; lines_written = 2.
- Short line:
  - Stimulus: 3 words 0xA, 0xB, 0xC with s_last on the third.
  - Response: one write with bits [95:0] = 0x0000000C_0000000B_0000000A and all higher bits 0. load_done = 1.
- Backpressure gaps:
  - Stimulus: s_valid toggling 1/0 over a 40-word line.
  - Response: same line data as the gap-free case; bram_we is asserted exactly once.
- Wrap:
  - Stimulus: load_base = 0xFFF, 2 full lines.
  - Response: writes at 0xFFF then 0x000; addr_wrap = 1.
- Abort:
  - Stimulus: load_abort asserted after 20 words of line 1, with line 0 already written.
  - Response: no further bram_we, no load_done; state IDLE; lines_written = 1. A new load_start loads normally.
- Parameter variant and reset:
  - Stimulus: MAC_NUM = 100 (LW = 500, WPL = 16), with 16 words of 0xFFFFFFFF.
  - Response: bits [499:0] all ones.
  - Stimulus: rst asserted mid-FILL.
  - Response: s_ready = 0 and busy = 0 immediately, with no clock edge required.

Source files
------------

// File: rtl/bram_weight_loader_if.sv
// rtl/bram_weight_loader_if.sv - word stream interface feeding the weight BRAM loader
// Purpose: carries the 32-bit word stream from the AXI slave data path into the loader.
// Signals:
//   s_data  : input word
//   s_valid : s_data is valid
//   s_last  : marks the final word of the load
//   s_ready : loader accepts a word this cycle
// Modports: master drives the stream, slave (the loader) returns s_ready.
interface bram_weight_loader_if #(
    parameter int IN_WIDTH = 32
);
    logic [IN_WIDTH-1:0] s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/bram_weight_loader.sv
// rtl/bram_weight_loader.sv - packs a 32-bit word stream into weight lines and writes them to BRAM port A
// Purpose: fills the weight BRAM before the MAC array reads it. Words are packed
// little-end-first into 5*MAC_NUM-bit lines; each full or s_last-terminated line is
// written to the next sequential address.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   load_start       : one-cycle pulse starting a load (IDLE only)
//   load_base        : first line address, latched on load_start
//   load_abort       : abandons the load, partial line discarded
//   s_if             : word stream (slave side)
//   bram_wr_data     : registered line data
//   bram_wr_address  : registered line address
//   bram_we, bram_en : write strobe / port enable, one cycle per line
//   busy             : high in FILL, WRITE or DONE
//   load_done        : one-cycle pulse at load completion
//   lines_written    : lines committed in the current or last load
//   addr_wrap        : sticky, address wrapped past all-ones
module bram_weight_loader #(
    parameter int MAC_NUM            = 256,
    parameter int BRAM_ADDRESS_WIDTH = 12,
    parameter int IN_WIDTH           = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_start,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] load_base,
    input  logic                          load_abort,
    bram_weight_loader_if.slave           s_if,
    output logic [5*MAC_NUM-1:0]          bram_wr_data,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_wr_address,
    output logic                          bram_we,
    output logic                          bram_en,
    output logic                          busy,
    output logic                          load_done,
    output logic [BRAM_ADDRESS_WIDTH:0]   lines_written,
    output logic                          addr_wrap
);
    localparam int LW  = 5 * MAC_NUM;
    localparam int WPL = (LW + IN_WIDTH - 1) / IN_WIDTH;
    localparam int CW  = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int AW  = BRAM_ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [LW-1:0]   line_q;
    logic [LW-1:0]   line_d;
    logic            last_seen_q;
    logic [AW-1:0]   addr_q;
    logic [LW-1:0]   wr_data_q;
    logic [AW-1:0]   wr_addr_q;
    logic            we_q;
    logic            done_q;
    logic [AW:0]     lines_q;
    logic            wrap_q;
    logic            xfer;
    logic            line_end;

    // s_ready is a pure decode of the state register, so an async reset drops it at once.
    assign s_if.s_ready = (state_q == FILL);
    assign xfer         = s_if.s_valid && (state_q == FILL);
    assign line_end     = s_if.s_last || (cnt_q == CW'(WPL - 1));

    // Line buffer with the incoming word merged at the current word slot. Bits of the
    // final word that fall above LW simply have no destination bit.
    always_comb begin
        line_d = line_q;
        for (int b = 0; b < LW; b++) begin
            if (cnt_q == CW'(b / IN_WIDTH)) begin
                line_d[b] = s_if.s_data[b % IN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            last_seen_q <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
            lines_q     <= '0;
            wrap_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (load_abort && state_q != IDLE) begin
                state_q <= IDLE;
                // The strobe of a WRITE cycle has already gone out, so that line is committed.
                if (state_q == WRITE) begin
                    addr_q  <= addr_q + 1'b1;
                    lines_q <= lines_q + 1'b1;
                    if (&addr_q) begin
                        wrap_q <= 1'b1;
                    end
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (load_start) begin
                            addr_q      <= load_base;
                            lines_q     <= '0;
                            wrap_q      <= 1'b0;
                            cnt_q       <= '0;
                            line_q      <= '0;
                            last_seen_q <= 1'b0;
                            state_q     <= FILL;
                        end
                    end
                    FILL: begin
                        if (xfer) begin
                            line_q <= line_d;
                            cnt_q  <= cnt_q + 1'b1;
                            if (line_end) begin
                                state_q     <= WRITE;
                                we_q        <= 1'b1;
                                wr_data_q   <= line_d;
                                wr_addr_q   <= addr_q;
                                last_seen_q <= s_if.s_last;
                            end
                        end
                    end
                    WRITE: begin
                        addr_q  <= addr_q + 1'b1;
                        lines_q <= lines_q + 1'b1;
                        if (&addr_q) begin
                            wrap_q <= 1'b1;
                        end
                        if (last_seen_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            cnt_q   <= '0;
                            line_q  <= '0;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bram_wr_data    = wr_data_q;
    assign bram_wr_address = wr_addr_q;
    assign bram_we         = we_q;
    assign bram_en         = we_q;
    assign busy            = (state_q != IDLE);
    assign load_done       = done_q;
    assign lines_written   = lines_q;
    assign addr_wrap       = wrap_q;
endmodule

// File: tb/tb_bram_weight_loader.sv
// tb/tb_bram_weight_loader.sv - directed self-checking bench for bram_weight_loader
module tb_bram_weight_loader;
    localparam int LW  = 1280;
    localparam int LW2 = 500;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // default DUT (MAC_NUM = 256)
    logic           load_start = 1'b0;
    logic [11:0]    load_base  = '0;
    logic           load_abort = 1'b0;
    logic [LW-1:0]  bram_wr_data;
    logic [11:0]    bram_wr_address;
    logic           bram_we, bram_en, busy, load_done, addr_wrap;
    logic [12:0]    lines_written;
    bram_weight_loader_if #(.IN_WIDTH(32)) sif ();

    bram_weight_loader #(.MAC_NUM(256), .BRAM_ADDRESS_WIDTH(12), .IN_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
        .load_abort(load_abort), .s_if(sif), .bram_wr_data(bram_wr_data),
        .bram_wr_address(bram_wr_address), .bram_we(bram_we), .bram_en(bram_en),
        .busy(busy), .load_done(load_done), .lines_written(lines_written),
        .addr_wrap(addr_wrap)
    );

    // parameter variant (MAC_NUM = 100, LW = 500, WPL = 16)
    logic           load_start2 = 1'b0;
    logic [11:0]    load_base2  = '0;
    logic           load_abort2 = 1'b0;
    logic [LW2-1:0] bram_wr_data2;
    logic [11:0]    bram_wr_address2;
    logic           bram_we2, bram_en2, busy2, load_done2, addr_wrap2;
    logic [12:0]    lines_written2;
    bram_weight_loader_if #(.IN_WIDTH(32)) sif2 ();

    bram_weight_loader #(.MAC_NUM(100), .BRAM_ADDRESS_WIDTH(12), .IN_WIDTH(32)) dut2 (
        .clk(clk), .rst(rst), .load_start(load_start2), .load_base(load_base2),
        .load_abort(load_abort2), .s_if(sif2), .bram_wr_data(bram_wr_data2),
        .bram_wr_address(bram_wr_address2), .bram_we(bram_we2), .bram_en(bram_en2),
        .busy(busy2), .load_done(load_done2), .lines_written(lines_written2),
        .addr_wrap(addr_wrap2)
    );

    // write monitor
    logic [11:0]   wr_addr[$];
    logic [LW-1:0] wr_data[$];
    int            wr_cyc[$];
    logic [LW-1:0] wr2_data[$];
    int            done_cnt = 0;
    int            done2_cnt = 0;
    int            en_bad = 0;

    always @(negedge clk) begin
        if (bram_we) begin
            wr_addr.push_back(bram_wr_address);
            wr_data.push_back(bram_wr_data);
            wr_cyc.push_back(cyc);
        end
        if (bram_we2) wr2_data.push_back({{(LW-LW2){1'b0}}, bram_wr_data2});
        if (load_done) done_cnt++;
        if (load_done2) done2_cnt++;
        if (bram_en !== bram_we || bram_en2 !== bram_we2) en_bad++;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] words[$];

    function automatic logic [LW-1:0] model_line(input int first, input int n);
        logic [LW-1:0] l;
        l = '0;
        for (int k = 0; k < n; k++) l[k*32 +: 32] = words[first + k];
        return l;
    endfunction

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        wr2_data.delete();
        done_cnt  = 0;
        done2_cnt = 0;
    endtask

    task automatic start_load(input bit second, input logic [11:0] base);
        if (second) begin load_start2 = 1'b1; load_base2 = base; end
        else        begin load_start  = 1'b1; load_base  = base; end
        @(posedge clk); #1;
        load_start  = 1'b0;
        load_start2 = 1'b0;
    endtask

    task automatic stream(input bit second, input bit with_last, input bit gaps);
        int  i     = 0;
        int  guard = 0;
        bit  tog   = 1'b0;
        bit  v, l, rdy;
        while (i < words.size() && guard < 3000) begin
            v = !(gaps && tog);
            l = v && with_last && (i == words.size() - 1);
            if (gaps) tog = !tog;
            if (second) begin
                sif2.s_valid = v; sif2.s_last = l; sif2.s_data = words[i]; rdy = sif2.s_ready;
            end else begin
                sif.s_valid = v; sif.s_last = l; sif.s_data = words[i]; rdy = sif.s_ready;
            end
            @(posedge clk); #1;
            if (v && rdy) i++;
            guard++;
        end
        sif.s_valid = 1'b0;  sif.s_last = 1'b0;
        sif2.s_valid = 1'b0; sif2.s_last = 1'b0;
        if (guard >= 3000) check("stream_timeout", LW'(i), LW'(words.size()));
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        sif.s_data  = '0; sif.s_valid  = 1'b0; sif.s_last  = 1'b0;
        sif2.s_data = '0; sif2.s_valid = 1'b0; sif2.s_last = 1'b0;

        // reset state
        #3;
        check("rst_we", LW'(bram_we), '0);
        check("rst_busy", LW'(busy), '0);
        check("rst_ready", LW'(sif.s_ready), '0);
        check("rst_data", bram_wr_data, '0);
        check("rst_lines", LW'(lines_written), '0);
        check("rst_wrap_done", LW'({addr_wrap, load_done}), '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // full load: 80 words, value = index
        clear_mon();
        words.delete();
        for (int i = 0; i < 80; i++) words.push_back(32'(i));
        start_load(1'b0, 12'h010);
        check("full_busy", LW'(busy), LW'(1));
        stream(1'b0, 1'b1, 1'b0);
        settle();
        check("full_nwr", LW'(wr_addr.size()), LW'(2));
        if (wr_addr.size() == 2) begin
            check("full_addr0", LW'(wr_addr[0]), LW'(12'h010));
            check("full_addr1", LW'(wr_addr[1]), LW'(12'h011));
            check("full_gap", LW'(wr_cyc[1] - wr_cyc[0]), LW'(41));
            check("full_l0_w0", LW'(wr_data[0][31:0]), LW'(0));
            check("full_l0_w39", LW'(wr_data[0][1279:1248]), LW'(39));
            check("full_l0", wr_data[0], model_line(0, 40));
            check("full_l1", wr_data[1], model_line(40, 40));
        end
        check("full_done", LW'(done_cnt), LW'(1));
        check("full_lines", LW'(lines_written), LW'(2));
        check("full_idle", LW'(busy), '0);

        // short line: 3 words, zero padded
        clear_mon();
        words.delete();
        words.push_back(32'hA); words.push_back(32'hB); words.push_back(32'hC);
        start_load(1'b0, 12'h020);
        stream(1'b0, 1'b1, 1'b0);
        settle();
        check("short_nwr", LW'(wr_addr.size()), LW'(1));
        if (wr_addr.size() == 1) begin
            check("short_addr", LW'(wr_addr[0]), LW'(12'h020));
            check("short_data", wr_data[0], {{(LW-96){1'b0}}, 96'h0000000C_0000000B_0000000A});
        end
        check("short_done", LW'(done_cnt), LW'(1));
        check("short_lines", LW'(lines_written), LW'(1));

        // backpressure gaps over one 40-word line
        clear_mon();
        words.delete();
        for (int i = 0; i < 40; i++) words.push_back(32'h1000 + 32'(i) * 3);
        start_load(1'b0, 12'h030);
        stream(1'b0, 1'b1, 1'b1);
        settle();
        check("gap_nwr", LW'(wr_addr.size()), LW'(1));
        if (wr_addr.size() == 1) check("gap_data", wr_data[0], model_line(0, 40));
        check("gap_done", LW'(done_cnt), LW'(1));

        // address wrap
        clear_mon();
        words.delete();
        for (int i = 0; i < 80; i++) words.push_back(32'd100 + 32'(i));
        start_load(1'b0, 12'hFFF);
        stream(1'b0, 1'b1, 1'b0);
        settle();
        check("wrap_nwr", LW'(wr_addr.size()), LW'(2));
        if (wr_addr.size() == 2) begin
            check("wrap_addr0", LW'(wr_addr[0]), LW'(12'hFFF));
            check("wrap_addr1", LW'(wr_addr[1]), LW'(12'h000));
        end
        check("wrap_flag", LW'(addr_wrap), LW'(1));

        // abort after 20 words of line 1
        clear_mon();
        words.delete();
        for (int i = 0; i < 60; i++) words.push_back(32'h5000 + 32'(i));
        start_load(1'b0, 12'h100);
        stream(1'b0, 1'b0, 1'b0);
        check("abort_pre_busy", LW'(busy), LW'(1));
        load_abort = 1'b1;
        @(posedge clk); #1;
        load_abort = 1'b0;
        settle();
        check("abort_nwr", LW'(wr_addr.size()), LW'(1));
        check("abort_done", LW'(done_cnt), '0);
        check("abort_busy", LW'(busy), '0);
        check("abort_ready", LW'(sif.s_ready), '0);
        check("abort_lines", LW'(lines_written), LW'(1));
        clear_mon();
        words.delete();
        words.push_back(32'h1); words.push_back(32'h2); words.push_back(32'h3);
        start_load(1'b0, 12'h200);
        stream(1'b0, 1'b1, 1'b0);
        settle();
        check("reload_nwr", LW'(wr_addr.size()), LW'(1));
        if (wr_addr.size() == 1) begin
            check("reload_addr", LW'(wr_addr[0]), LW'(12'h200));
            check("reload_data", wr_data[0], {{(LW-96){1'b0}}, 96'h00000003_00000002_00000001});
        end
        check("reload_done", LW'(done_cnt), LW'(1));

        // parameter variant: 16 words of all ones fill a 500-bit line
        clear_mon();
        words.delete();
        for (int i = 0; i < 16; i++) words.push_back(32'hFFFF_FFFF);
        start_load(1'b1, 12'h040);
        stream(1'b1, 1'b1, 1'b0);
        settle();
        check("var_nwr", LW'(wr2_data.size()), LW'(1));
        if (wr2_data.size() == 1) check("var_data", wr2_data[0], {{(LW-LW2){1'b0}}, {LW2{1'b1}}});
        check("var_done", LW'(done2_cnt), LW'(1));
        check("var_lines", LW'(lines_written2), LW'(1));

        check("en_eq_we", LW'(en_bad), '0);

        // asynchronous reset mid-FILL
        start_load(1'b0, 12'h300);
        sif.s_valid = 1'b1;
        sif.s_data  = 32'h77;
        repeat (5) @(posedge clk);
        #1;
        check("midfill_ready", LW'(sif.s_ready), LW'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_ready", LW'(sif.s_ready), '0);
        check("arst_busy", LW'(busy), '0);
        check("arst_lines", LW'(lines_written), '0);
        check("arst_data", bram_wr_data, '0);
        sif.s_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
